// File: rtl/act_sel_pipe_pkg.sv
// Shared constants and select-index helper for the select-register cell family.
package act_pkg;

  // Per-bit select mode: AND or OR of the A/B operand pair.
  localparam logic SEL_AND = 1'b0;
  localparam logic SEL_OR  = 1'b1;

  // Widest select vector the helper accepts; callers zero-extend to this width.
  localparam int unsigned SEL_MAX = 16;

  // Forms S[i] = mode[i] ? A[i] | B[i] : A[i] & B[i] and returns S as an unsigned index.
  function automatic int unsigned sel_index(input logic [SEL_MAX-1:0] a,
                                            input logic [SEL_MAX-1:0] b,
                                            input logic [SEL_MAX-1:0] mode);
    logic [SEL_MAX-1:0] s;
    for (int i = 0; i < SEL_MAX; i++) begin
      s[i] = (mode[i] == SEL_OR) ? (a[i] | b[i]) : (a[i] & b[i]);
    end
    return 32'(s);
  endfunction

endpackage

// File: rtl/act_sel_pipe_if.sv
// Data/select/control bundle between an operand source and the select pipeline.
interface act_sel_pipe_if #(
  parameter int unsigned N        = 5,
  parameter int unsigned SEL_BITS = 2,
  parameter int unsigned CNT_W    = 8
);
  logic [N*(2**SEL_BITS)-1:0] D;
  logic [SEL_BITS-1:0]        A;
  logic [SEL_BITS-1:0]        B;
  logic                       in_valid;
  logic                       HOLD;
  logic                       SCLR;
  logic [N-1:0]               out;
  logic                       out_valid;
  logic [CNT_W-1:0]           out_cnt;

  // Source side: drives words, select operands and pipeline control.
  modport master (
    output D, A, B, in_valid, HOLD, SCLR,
    input  out, out_valid, out_cnt
  );

  // Pipeline side.
  modport slave (
    input  D, A, B, in_valid, HOLD, SCLR,
    output out, out_valid, out_cnt
  );
endinterface

// File: rtl/act_sel_pipe_stage.sv
// One pipeline stage: W-bit register with async clear, sync flush and hold.
module act_sel_stage #(
  parameter int unsigned W = 6
) (
  input  logic         CLK,
  input  logic         CLR,
  input  logic         i_sclr,
  input  logic         i_hold,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  // Flush beats hold; hold freezes the stage.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      r_q <= '0;
    end else if (i_sclr) begin
      r_q <= '0;
    end else if (!i_hold) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/act_sel_pipe.sv
// Select-register cell: mode-masked select of one data word, DEPTH-stage valid
// pipeline with hold/flush, and a delivered-word counter.
module act_sel_pipe
  import act_pkg::*;
#(
  parameter int unsigned         N        = 5,
  parameter int unsigned         SEL_BITS = 2,
  parameter logic [SEL_BITS-1:0] SEL_MODE = 2'b10,
  parameter int unsigned         DEPTH    = 2,
  parameter int unsigned         CNT_W    = 8
) (
  input  logic          CLK,
  input  logic          CLR,
  act_sel_pipe_if.slave io_bus
);

  logic [SEL_BITS-1:0] w_sel_idx;
  logic [N-1:0]        w_sel_word;
  logic [N:0]          w_stage_d [DEPTH];
  logic [N:0]          w_stage_q [DEPTH];
  logic                w_advance;
  logic [CNT_W-1:0]    r_cnt;

  // Index is always in range, so the part-select never yields X.
  always_comb begin
    w_sel_idx  = SEL_BITS'(sel_index(SEL_MAX'(io_bus.A), SEL_MAX'(io_bus.B),
                                     SEL_MAX'(SEL_MODE)));
    w_sel_word = io_bus.D[w_sel_idx*N +: N];
  end

  // Bubbles still carry their data; only the valid bit marks real samples.
  assign w_stage_d[0] = {io_bus.in_valid, w_sel_word};

  genvar g;
  generate
    for (g = 0; g < int'(DEPTH); g++) begin : g_stage
      if (g > 0) begin : g_link
        assign w_stage_d[g] = w_stage_q[g-1];
      end
      act_sel_stage #(
        .W (N + 1)
      ) u_stage (
        .CLK    (CLK),
        .CLR    (CLR),
        .i_sclr (io_bus.SCLR),
        .i_hold (io_bus.HOLD),
        .i_d    (w_stage_d[g]),
        .o_q    (w_stage_q[g])
      );
    end
  endgenerate

  assign w_advance = !io_bus.SCLR && !io_bus.HOLD;

  // Count a word when a valid value is loaded into the last stage; wraps silently.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      r_cnt <= '0;
    end else if (w_advance && w_stage_d[DEPTH-1][N]) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign io_bus.out       = w_stage_q[DEPTH-1][N-1:0];
  assign io_bus.out_valid = w_stage_q[DEPTH-1][N];
  assign io_bus.out_cnt   = r_cnt;

endmodule

// File: tb/tb_act_sel_pipe.sv
// Directed bench for act_sel_pipe: default instance with a scoreboard, plus a
// DEPTH=1, SEL_BITS=3 instance for the parameter sweep.
module tb_act_sel_pipe;

  logic CLK = 1'b0;
  logic CLR = 1'b1;
  always #5 CLK = ~CLK;

  act_sel_pipe_if #(.N(5), .SEL_BITS(2), .CNT_W(8)) bus0 ();
  act_sel_pipe_if #(.N(8), .SEL_BITS(3), .CNT_W(8)) bus1 ();

  act_sel_pipe #(
    .N(5), .SEL_BITS(2), .SEL_MODE(2'b10), .DEPTH(2), .CNT_W(8)
  ) u_dut0 (
    .CLK    (CLK),
    .CLR    (CLR),
    .io_bus (bus0)
  );

  act_sel_pipe #(
    .N(8), .SEL_BITS(3), .SEL_MODE(3'b101), .DEPTH(1), .CNT_W(8)
  ) u_dut1 (
    .CLK    (CLK),
    .CLR    (CLR),
    .io_bus (bus1)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [4:0] w0 [4];
  logic [7:0] w1 [8];
  logic [4:0] sb_q [$];
  logic [7:0] exp_cnt;
  logic [4:0] last_exp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic drive_words0();
    bus0.D = {w0[3], w0[2], w0[1], w0[0]};
  endtask

  // Reference select for SEL_MODE = 2'b10: S1 = A1|B1, S0 = A0&B0.
  function automatic logic [4:0] ref_word0(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] s;
    s = {a[1] | b[1], a[0] & b[0]};
    return w0[s];
  endfunction

  // One clock: push the expected word, step the edge, then score the output.
  task automatic tick();
    logic adv;
    adv = !bus0.HOLD && !bus0.SCLR;
    if (bus0.SCLR) sb_q.delete();
    else if (adv && bus0.in_valid) sb_q.push_back(ref_word0(bus0.A, bus0.B));
    @(posedge CLK);
    #1;
    if (adv && bus0.out_valid) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_valid", 32'(bus0.out), 32'h1f_ffff);
      end else begin
        last_exp = sb_q.pop_front();
        chk("sb_data", 32'(bus0.out), 32'(last_exp));
        exp_cnt = exp_cnt + 8'd1;
      end
    end
    chk("sb_cnt", 32'(bus0.out_cnt), 32'(exp_cnt));
  endtask

  task automatic pulse_clr();
    #2 CLR = 1'b1;
    #1;
    chk("clr_out", 32'(bus0.out), 32'd0);
    chk("clr_valid", 32'(bus0.out_valid), 32'd0);
    chk("clr_cnt", 32'(bus0.out_cnt), 32'd0);
    CLR = 1'b0;
    sb_q.delete();
    exp_cnt = 8'd0;
  endtask

  task automatic rand_valid_word();
    for (int k = 0; k < 4; k++) w0[k] = 5'($urandom);
    drive_words0();
    bus0.A = 2'($urandom);
    bus0.B = 2'($urandom);
    bus0.in_valid = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [4:0] tt_exp [4];
    logic [1:0] tt_a [4];
    logic [1:0] tt_b [4];
    tt_a = '{2'b00, 2'b01, 2'b10, 2'b11};
    tt_b = '{2'b00, 2'b01, 2'b00, 2'b01};
    tt_exp = '{5'h03, 5'h15, 5'h0A, 5'h1C};

    exp_cnt = 8'd0;
    last_exp = 5'd0;
    w0 = '{5'h03, 5'h15, 5'h0A, 5'h1C};
    drive_words0();
    bus0.A = '0; bus0.B = '0; bus0.in_valid = 1'b0; bus0.HOLD = 1'b0; bus0.SCLR = 1'b0;
    for (int k = 0; k < 8; k++) w1[k] = 8'(8'h30 + 8'h11 * k);
    bus1.D = {w1[7], w1[6], w1[5], w1[4], w1[3], w1[2], w1[1], w1[0]};
    bus1.A = '0; bus1.B = '0; bus1.in_valid = 1'b0; bus1.HOLD = 1'b0; bus1.SCLR = 1'b0;

    // Reset state while CLR is held.
    #11;
    chk("rst_out", 32'(bus0.out), 32'd0);
    chk("rst_valid", 32'(bus0.out_valid), 32'd0);
    chk("rst_cnt", 32'(bus0.out_cnt), 32'd0);
    CLR = 1'b0;

    // Truth table: each word appears two edges after it is selected.
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        bus0.A = tt_a[i];
        bus0.B = tt_b[i];
        bus0.in_valid = 1'b1;
      end else begin
        bus0.in_valid = 1'b0;
      end
      tick();
      if (i >= 1 && i <= 4) begin
        chk("tt_out", 32'(bus0.out), 32'(tt_exp[i-1]));
        chk("tt_valid", 32'(bus0.out_valid), 32'd1);
      end
    end

    // Async clear with words in flight, then two empty edges after release.
    rand_valid_word();
    tick();
    rand_valid_word();
    tick();
    pulse_clr();
    bus0.in_valid = 1'b0;
    tick();
    chk("post_clr_valid0", 32'(bus0.out_valid), 32'd0);
    tick();
    chk("post_clr_valid1", 32'(bus0.out_valid), 32'd0);

    // Hold: four words, three frozen cycles, then drain.
    for (int i = 0; i < 4; i++) begin
      rand_valid_word();
      tick();
    end
    bus0.HOLD = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_valid_word();
      tick();
      chk("hold_out", 32'(bus0.out), 32'(last_exp));
      chk("hold_valid", 32'(bus0.out_valid), 32'd1);
    end
    bus0.HOLD = 1'b0;
    bus0.in_valid = 1'b0;
    tick();
    tick();
    chk("hold_cnt_end", 32'(bus0.out_cnt), 32'd4);

    // Flush and hold on the same edge: flush wins, counter untouched.
    rand_valid_word();
    tick();
    rand_valid_word();
    tick();
    bus0.SCLR = 1'b1;
    bus0.HOLD = 1'b1;
    rand_valid_word();
    tick();
    chk("sclr_valid", 32'(bus0.out_valid), 32'd0);
    chk("sclr_out", 32'(bus0.out), 32'd0);
    chk("sclr_cnt", 32'(bus0.out_cnt), 32'd5);
    bus0.SCLR = 1'b0;
    bus0.HOLD = 1'b0;
    bus0.in_valid = 1'b0;
    tick();
    chk("sclr_stage0_out", 32'(bus0.out), 32'd0);
    chk("sclr_stage0_valid", 32'(bus0.out_valid), 32'd0);

    // Counter wrap with interleaved bubbles.
    pulse_clr();
    for (int i = 0; i < 255; i++) begin
      rand_valid_word();
      tick();
      if (i % 16 == 7) begin
        bus0.in_valid = 1'b0;
        tick();
      end
    end
    bus0.in_valid = 1'b0;
    tick();
    tick();
    chk("wrap_cnt_ff", 32'(bus0.out_cnt), 32'hFF);
    rand_valid_word();
    tick();
    bus0.in_valid = 1'b0;
    tick();
    tick();
    chk("wrap_cnt_00", 32'(bus0.out_cnt), 32'h00);

    // Sweep instance: SEL_MODE=3'b101, DEPTH=1, one-edge latency.
    chk("sw_idle_valid", 32'(bus1.out_valid), 32'd0);
    bus1.A = 3'b100; bus1.B = 3'b011; bus1.in_valid = 1'b1;
    tick();
    chk("sw_out_5a", 32'(bus1.out), 32'(w1[5]));
    chk("sw_valid", 32'(bus1.out_valid), 32'd1);
    bus1.A = 3'b000; bus1.B = 3'b111;
    tick();
    chk("sw_out_5b", 32'(bus1.out), 32'(w1[5]));
    bus1.A = 3'b011; bus1.B = 3'b010;
    tick();
    chk("sw_out_3", 32'(bus1.out), 32'(w1[3]));
    bus1.A = 3'b010; bus1.B = 3'b000;
    tick();
    chk("sw_out_0", 32'(bus1.out), 32'(w1[0]));
    bus1.in_valid = 1'b0;
    tick();
    chk("sw_bubble_valid", 32'(bus1.out_valid), 32'd0);
    chk("sw_cnt", 32'(bus1.out_cnt), 32'd4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
